// File: rtl/pwm_deadtime_if.sv
// Bundles the duty handshake, triangle/deadtime inputs and the complementary
// PWM outputs for pwm_deadtime.
interface pwm_deadtime_if #(
  parameter int N    = 8,
  parameter int DT_W = 4
);
  logic [N-1:0]    triangle;
  logic [N-1:0]    duty;
  logic            duty_valid;
  logic            duty_ready;
  logic [DT_W-1:0] deadtime;
  logic            out_hi;
  logic            out_lo;
  logic            duty_applied;

  modport master (
    output triangle, duty, duty_valid, deadtime,
    input  duty_ready, out_hi, out_lo, duty_applied
  );

  modport slave (
    input  triangle, duty, duty_valid, deadtime,
    output duty_ready, out_hi, out_lo, duty_applied
  );
endinterface

// File: rtl/pwm_deadtime.sv
// Center-aligned PWM from a triangle count, with a shadowed duty register
// and a complementary output pair separated by programmable dead time.
module pwm_deadtime #(
  parameter int N    = 8,
  parameter int DT_W = 4
) (
  input logic           clk,
  input logic           rst,
  pwm_deadtime_if.slave bus
);

  typedef enum logic [1:0] {
    HI_ON,
    DEAD_TO_LO,
    LO_ON,
    DEAD_TO_HI
  } state_t;

  localparam logic [DT_W-1:0] DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

  state_t          state;
  logic [DT_W-1:0] dcnt;
  logic [N-1:0]    active_duty;
  logic [N-1:0]    pending_duty;
  logic            pending;
  logic            raw_q;
  logic            out_hi_q;
  logic            out_lo_q;
  logic            duty_applied_q;

  assign bus.duty_ready   = ~pending;
  assign bus.out_hi       = out_hi_q;
  assign bus.out_lo       = out_lo_q;
  assign bus.duty_applied = duty_applied_q;

  // Shadow duty only swaps in at the triangle bottom so a period is never cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_duty    <= '0;
      pending_duty   <= '0;
      pending        <= 1'b0;
      raw_q          <= 1'b0;
      duty_applied_q <= 1'b0;
    end else begin
      duty_applied_q <= 1'b0;
      if (pending && (bus.triangle == '0)) begin
        active_duty    <= pending_duty;
        pending        <= 1'b0;
        duty_applied_q <= 1'b1;
      end else if (bus.duty_valid && !pending) begin
        pending_duty <= bus.duty;
        pending      <= 1'b1;
      end
      raw_q <= (bus.triangle < active_duty);
    end
  end

  // Outputs are decoded from the state being entered, so they stay registered.
  // A dead state that sees raw revert returns to its origin: the far side was never driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DEAD_TO_LO;
      dcnt     <= bus.deadtime;
      out_hi_q <= 1'b0;
      out_lo_q <= 1'b0;
    end else begin
      out_hi_q <= 1'b0;
      out_lo_q <= 1'b0;
      case (state)
        HI_ON: begin
          if (!raw_q) begin
            state <= DEAD_TO_LO;
            dcnt  <= bus.deadtime;
          end else begin
            out_hi_q <= 1'b1;
          end
        end
        DEAD_TO_LO: begin
          if (raw_q) begin
            state    <= HI_ON;
            out_hi_q <= 1'b1;
          end else if (dcnt == '0) begin
            state    <= LO_ON;
            out_lo_q <= 1'b1;
          end else begin
            dcnt <= dcnt - DT_ONE;
          end
        end
        LO_ON: begin
          if (raw_q) begin
            state <= DEAD_TO_HI;
            dcnt  <= bus.deadtime;
          end else begin
            out_lo_q <= 1'b1;
          end
        end
        DEAD_TO_HI: begin
          if (!raw_q) begin
            state    <= LO_ON;
            out_lo_q <= 1'b1;
          end else if (dcnt == '0) begin
            state    <= HI_ON;
            out_hi_q <= 1'b1;
          end else begin
            dcnt <= dcnt - DT_ONE;
          end
        end
        default: begin
          state <= DEAD_TO_LO;
          dcnt  <= bus.deadtime;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and randomized stimulus for pwm_deadtime, checked every cycle
// against a behavioural model of the shadow duty and dead-time rules.
module tb_pwm_deadtime;

  logic clk = 1'b0;
  logic rst;

  pwm_deadtime_if #(.N(8), .DT_W(4)) bus ();

  pwm_deadtime #(.N(8), .DT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the side the outputs want (target_hi) and the remaining gap (-1 = side is on)
  logic [7:0] m_active;
  logic [7:0] m_pdut;
  logic       m_pending;
  logic       m_raw;
  logic       m_applied;
  logic       m_target_hi;
  int         m_gap;
  logic       m_hi;
  logic       m_lo;

  function automatic void model_step(input logic r, input logic [7:0] tv,
                                     input logic [7:0] dv, input logic valid,
                                     input logic [3:0] dt);
    logic want_hi;
    logic new_raw;
    if (r) begin
      m_active    = 8'd0;
      m_pending   = 1'b0;
      m_raw       = 1'b0;
      m_applied   = 1'b0;
      m_target_hi = 1'b0;
      m_gap       = int'(dt);
    end else begin
      want_hi = m_raw;
      new_raw = (tv < m_active);
      m_applied = m_pending && (tv == 8'd0);
      if (m_applied) begin
        m_active  = m_pdut;
        m_pending = 1'b0;
      end else if (valid && !m_pending) begin
        m_pdut    = dv;
        m_pending = 1'b1;
      end
      m_raw = new_raw;
      if (want_hi != m_target_hi) begin
        m_target_hi = want_hi;
        m_gap = (m_gap < 0) ? int'(dt) : -1;
      end else if (m_gap >= 0) begin
        m_gap = m_gap - 1;
      end
    end
    m_hi = (m_gap < 0) && m_target_hi;
    m_lo = (m_gap < 0) && !m_target_hi;
  endfunction

  task automatic check_output(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s got=%0b expected=%0b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic [7:0] tv,
                                input logic [7:0] dv, input logic valid,
                                input logic [3:0] dt);
    rst            = r;
    bus.triangle   = tv;
    bus.duty       = dv;
    bus.duty_valid = valid;
    bus.deadtime   = dt;
    @(posedge clk);
    model_step(r, tv, dv, valid, dt);
    #1;
    check_output("out_hi", bus.out_hi, m_hi);
    check_output("out_lo", bus.out_lo, m_lo);
    check_output("duty_ready", bus.duty_ready, !m_pending);
    check_output("duty_applied", bus.duty_applied, m_applied);
    check_output("no_overlap", bus.out_hi & bus.out_lo, 1'b0);
  endtask

  task automatic ramp(input int from, input int to, input logic [3:0] dt);
    int step;
    step = (to >= from) ? 1 : -1;
    for (int v = from; v != to + step; v += step)
      apply_stimulus(1'b0, 8'(v), 8'd0, 1'b0, dt);
  endtask

  initial begin
    logic [7:0] tv;
    logic [7:0] dv;
    int         dir;

    $display("[TB] start");
    bus.triangle   = 8'd0;
    bus.duty       = 8'd0;
    bus.duty_valid = 1'b0;
    bus.deadtime   = 4'd0;
    rst            = 1'b1;
    #2;

    // Reset and power-up dead interval toward the low side
    apply_stimulus(1'b1, 8'd0, 8'd0, 1'b0, 4'd3);
    apply_stimulus(1'b1, 8'd0, 8'd0, 1'b0, 4'd3);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 4'd3);

    // Shadowed duty accepted mid-sweep, applied at the bottom
    apply_stimulus(1'b0, 8'd57, 8'd100, 1'b1, 4'd3);
    ramp(58, 255, 4'd3);
    ramp(254, 0, 4'd3);
    ramp(1, 255, 4'd3);
    ramp(254, 1, 4'd3);

    // Half duty with two-cycle dead time over full periods
    apply_stimulus(1'b0, 8'd0, 8'd128, 1'b1, 4'd2);
    ramp(1, 255, 4'd2);
    ramp(254, 0, 4'd2);
    for (int p = 0; p < 2; p++) begin
      ramp(1, 255, 4'd2);
      ramp(254, 0, 4'd2);
    end

    // Zero dead time still leaves a one-cycle gap
    apply_stimulus(1'b0, 8'd5, 8'd1, 1'b1, 4'd0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'd1, 8'd0, 1'b0, 4'd0);
    end

    // One-cycle raw glitch while the high side is on
    apply_stimulus(1'b0, 8'd5, 8'd100, 1'b1, 4'd5);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 4'd5);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 8'd98, 8'd0, 1'b0, 4'd5);
    apply_stimulus(1'b0, 8'd100, 8'd0, 1'b0, 4'd5);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 8'd99, 8'd0, 1'b0, 4'd5);

    // Reset with a duty still pending
    apply_stimulus(1'b0, 8'd30, 8'd50, 1'b1, 4'd3);
    apply_stimulus(1'b1, 8'd30, 8'd0, 1'b0, 4'd3);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 4'd3);

    // Full-scale duty: low only at the top of the triangle
    apply_stimulus(1'b0, 8'd0, 8'd255, 1'b1, 4'd1);
    ramp(0, 255, 4'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'd255, 8'd0, 1'b0, 4'd1);
    ramp(254, 0, 4'd1);

    // Randomized walk with occasional jumps, resets and edge-value duties
    tv  = 8'd0;
    dir = 1;
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 3))
        0:       dv = 8'd0;
        1:       dv = 8'd255;
        default: dv = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 15) == 0) tv = 8'($urandom_range(0, 3));
      else if ($urandom_range(0, 31) == 0) tv = 8'($urandom_range(0, 255));
      else begin
        if (tv == 8'd255) dir = -1;
        if (tv == 8'd0) dir = 1;
        tv = 8'(int'(tv) + dir * 5 > 255 ? 255 : (int'(tv) + dir * 5 < 0 ? 0 : int'(tv) + dir * 5));
      end
      apply_stimulus(($urandom_range(0, 199) == 0), tv, dv,
                     $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
